// File: rtl/cm_sequencer_if.sv
// Instruction / load channel between the instruction source and cm_sequencer.
//   instr_valid/instr_ready : push handshake for {instr_op, instr_dst}
//   instr_op                : opcode forwarded to cm
//   instr_dst               : writeback target (00 R0, 01 R1, 10 R2, 11 R_EXTRA only)
//   load_en/load_sel/load_data : direct operand register load (honoured only when idle)
interface cm_sequencer_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] instr_op;
    logic [1:0] instr_dst;
    logic       load_en;
    logic [1:0] load_sel;
    logic [2:0] load_data;

    modport master (
        output instr_valid, instr_op, instr_dst, load_en, load_sel, load_data,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_dst, load_en, load_sel, load_data,
        output instr_ready
    );
endinterface

// File: rtl/cm_sequencer.sv
// Sequencing controller for the cm micro-operation unit.
// Holds operand registers R0..R2, queues {op, dst} instructions in a DEPTH-entry
// FIFO, drives each op to cm for one settle cycle (ISSUE) plus one capture cycle
// (CAPTURE), then latches cm_result into r_extra and optionally writes it back.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : instruction push + direct load channel (slave side)
//   r0, r1, r2   : operand registers to cm
//   cm_opcode    : opcode to cm (00 while idle)
//   cm_result    : cm combinational result
//   r_extra      : last captured result
//   done         : one-cycle pulse per completed instruction
//   busy         : FSM not idle or FIFO not empty
module cm_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    cm_sequencer_if.slave    bus,
    output logic [2:0]       r0,
    output logic [2:0]       r1,
    output logic [2:0]       r2,
    output logic [1:0]       cm_opcode,
    input  logic [2:0]       cm_result,
    output logic [2:0]       r_extra,
    output logic             done,
    output logic             busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      regs_q [3];
    logic [2:0]      regs_d [3];
    logic [2:0]      r_extra_q, r_extra_d;
    logic [1:0]      cm_opcode_q, cm_opcode_d;
    logic            done_q, done_d;

    logic [1:0]      op_mem_q  [DEPTH];
    logic [1:0]      dst_mem_q [DEPTH];

    logic            full, push, pop, load_ok;
    logic [CW-1:0]   count_after_pop;
    logic [1:0]      head_next_op;
    logic [1:0]      head_dst;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        push     = bus.instr_valid && !full;
        pop      = (state_q == CAPTURE);
        busy     = (state_q != IDLE) || (count_q != '0);
        load_ok  = bus.load_en && !busy && (bus.load_sel != 2'b11);
        head_dst = dst_mem_q[rd_ptr_q];

        wr_ptr_d        = wr_ptr_q + AW'(push);
        rd_ptr_d        = rd_ptr_q + AW'(pop);
        count_after_pop = count_q - CW'(pop);
        count_d         = count_after_pop + CW'(push);

        // Head seen after this edge: if the FIFO drains to empty, a push
        // landing on this same edge becomes the head and is read straight
        // from the input rather than from storage not yet written.
        head_next_op = (count_after_pop == '0) ? bus.instr_op : op_mem_q[rd_ptr_d];

        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0 || push) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = (count_d != '0) ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase

        // Opcode is registered; it reloads whenever a new instruction starts
        // and holds across ISSUE->CAPTURE so cm sees a stable op for 2 cycles.
        if (state_d == IDLE)
            cm_opcode_d = 2'b00;
        else if (state_q == ISSUE)
            cm_opcode_d = cm_opcode_q;
        else
            cm_opcode_d = head_next_op;

        regs_d    = regs_q;
        r_extra_d = r_extra_q;
        done_d    = pop;
        if (pop) begin
            r_extra_d = cm_result;
            if (head_dst != 2'b11) regs_d[head_dst] = cm_result;
        end
        // Loads only happen when idle, so they never collide with writeback.
        if (load_ok) regs_d[bus.load_sel] = bus.load_data;
    end

    assign bus.instr_ready = !full;
    assign r0        = regs_q[0];
    assign r1        = regs_q[1];
    assign r2        = regs_q[2];
    assign r_extra   = r_extra_q;
    assign cm_opcode = cm_opcode_q;
    assign done      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            regs_q[0]   <= '0;
            regs_q[1]   <= '0;
            regs_q[2]   <= '0;
            r_extra_q   <= '0;
            cm_opcode_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            regs_q      <= regs_d;
            r_extra_q   <= r_extra_d;
            cm_opcode_q <= cm_opcode_d;
            done_q      <= done_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem_q[wr_ptr_q]  <= bus.instr_op;
            dst_mem_q[wr_ptr_q] <= bus.instr_dst;
        end
    end
endmodule

// File: tb/tb_cm_sequencer.sv
module tb_cm_sequencer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] r0, r1, r2, r_extra, cm_result;
    logic [1:0] cm_opcode;
    logic       done, busy;

    cm_sequencer_if bus();

    cm_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .r0(r0), .r1(r1), .r2(r2),
        .cm_opcode(cm_opcode), .cm_result(cm_result),
        .r_extra(r_extra), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // cm stub
    always_comb begin
        case (cm_opcode)
            2'b00:   cm_result = r0 + r1;
            2'b01:   cm_result = r1 ^ r2;
            2'b10:   cm_result = r0 & r2;
            default: cm_result = r0 | r1 | r2;
        endcase
    end

    int checks = 0;
    int errors = 0;

    // Transaction-level reference model: each instruction completes two edges
    // after it may start; it starts at its push edge or when the previous one
    // completes, whichever is later.
    typedef struct {
        logic [1:0] op;
        logic [1:0] dst;
        int         comp;
    } ent_t;

    ent_t       q[$];
    logic [2:0] m_r [3];
    logic [2:0] m_rx;
    logic       m_done;
    int         cyc;
    int         last_comp;
    bit         last_push;

    function automatic logic [2:0] model_op(input logic [1:0] op);
        int a, b, c;
        a = m_r[0]; b = m_r[1]; c = m_r[2];
        case (op)
            2'b00:   return 3'((a + b) % 8);
            2'b01:   return 3'(a ^ 0 ^ (b ^ c) ^ a);
            2'b10:   return 3'(a & c);
            default: return 3'(a | b | c);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_r[0] = 0; m_r[1] = 0; m_r[2] = 0;
        m_rx = 0; m_done = 0; last_comp = 0;
    endtask

    // Called at a negedge: check outputs, drive inputs, advance one edge.
    task automatic tick(input logic v, input logic [1:0] op, input logic [1:0] dst,
                        input logic le, input logic [1:0] ls, input logic [2:0] ld);
        bit rdy, bsy;
        ent_t e;
        logic [2:0] res;
        int start;
        rdy = (q.size() < DEPTH);
        bsy = (q.size() != 0);
        chk("instr_ready", 8'(bus.instr_ready), 8'(rdy));
        chk("busy", 8'(busy), 8'(bsy));
        chk("r0", 8'(r0), 8'(m_r[0]));
        chk("r1", 8'(r1), 8'(m_r[1]));
        chk("r2", 8'(r2), 8'(m_r[2]));
        chk("r_extra", 8'(r_extra), 8'(m_rx));
        chk("done", 8'(done), 8'(m_done));
        chk("cm_opcode", 8'(cm_opcode), 8'(bsy ? q[0].op : 2'b00));
        bus.instr_valid = v;  bus.instr_op = op;  bus.instr_dst = dst;
        bus.load_en = le;     bus.load_sel = ls;  bus.load_data = ld;
        @(posedge clk);
        cyc++;
        last_push = v && rdy;
        m_done = 0;
        if (q.size() != 0 && q[0].comp == cyc) begin
            res = model_op(q[0].op);
            m_rx = res;
            if (q[0].dst != 2'b11) m_r[q[0].dst] = res;
            void'(q.pop_front());
            m_done = 1;
        end
        if (le && !bsy && ls != 2'b11) m_r[ls] = ld;
        if (last_push) begin
            start = (cyc > last_comp) ? cyc : last_comp;
            e.op = op; e.dst = dst; e.comp = start + 2;
            last_comp = e.comp;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 2'b00, 2'b00, 0, 2'b00, 3'b000);
    endtask

    task automatic push(input logic [1:0] op, input logic [1:0] dst);
        tick(1, op, dst, 0, 2'b00, 3'b000);
    endtask

    task automatic load(input logic [1:0] sel, input logic [2:0] d);
        tick(0, 2'b00, 2'b00, 1, sel, d);
    endtask

    initial begin
        int accepted, guard;
        cyc = 0;
        model_reset();
        bus.instr_valid = 0; bus.instr_op = 0; bus.instr_dst = 0;
        bus.load_en = 0; bus.load_sel = 0; bus.load_data = 0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_ready", 8'(bus.instr_ready), 8'd1);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_opcode", 8'(cm_opcode), 8'd0);
        chk("rst_rx", 8'(r_extra), 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single instruction
        load(2'b00, 3'b001); load(2'b01, 3'b100); load(2'b10, 3'b010);
        push(2'b00, 2'b11);
        idle(3);
        chk("s1_rextra", 8'(r_extra), 8'h5);
        chk("s1_r0", 8'(r0), 8'h1);

        // back-to-back, all ops
        push(2'b00, 2'b11); push(2'b01, 2'b11); push(2'b10, 2'b11); push(2'b11, 2'b11);
        idle(7);
        chk("b2b_rextra", 8'(r_extra), 8'h7);
        chk("b2b_busy", 8'(busy), 8'h0);

        // dependent chain
        push(2'b00, 2'b10); push(2'b01, 2'b00);
        idle(5);
        chk("dep_r2", 8'(r2), 8'h5);
        chk("dep_r0", 8'(r0), 8'h1);

        // overfill with valid held high
        accepted = 0; guard = 0;
        while (accepted < DEPTH + 2 && guard < 100) begin
            tick(1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0, 2'b00, 3'b000);
            if (last_push) accepted++;
            guard++;
        end
        chk("fill_accepted", 8'(accepted), 8'(DEPTH + 2));
        idle(2 * DEPTH + 6);
        chk("fill_drained", 8'(busy), 8'h0);

        // load while busy, then idle, then ignored select
        push(2'b11, 2'b11);
        load(2'b01, 3'b111);
        idle(3);
        load(2'b01, 3'b111);
        chk("load_r1", 8'(r1), 8'h7);
        load(2'b11, 3'b101);
        idle(1);

        // random traffic
        for (int i = 0; i < 300; i++)
            tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        idle(2 * DEPTH + 4);

        // reset during CAPTURE
        load(2'b00, 3'b011);
        push(2'b00, 2'b00);
        idle(1);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 8'(bus.instr_ready), 8'd1);
        chk("arst_busy", 8'(busy), 8'd0);
        chk("arst_r0", 8'(r0), 8'd0);
        chk("arst_done", 8'(done), 8'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
